// File: rtl/st7735_pkg.sv
// Shared ST7735 constants: command codes, default panel geometry and the
// panel-side command decoder state encoding.
package st7735_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 160;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET0,
    ST_CASET1,
    ST_CASET2,
    ST_CASET3,
    ST_RASET0,
    ST_RASET1,
    ST_RASET2,
    ST_RASET3,
    ST_RAMWR,
    ST_SKIP
  } dec_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: synchronises the panel pins into the system clock domain,
// detects LCD_CLK rising edges and assembles MSB-first bytes tagged with DC.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       dc,
  input  logic       sclk,
  input  logic       lcd_rst_n,
  output logic       core_rst,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] rstn_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic [1:0] dc_sync;
  logic [1:0] sclk_sync;
  logic       sclk_q;
  logic       sclk_rise;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       done;
  logic       dc_lat;

  always_ff @(posedge clk) begin
    if (rst) rstn_sync <= '0;
    else     rstn_sync <= {rstn_sync[0], lcd_rst_n};
  end

  // The panel reset pin behaves exactly like RESET once synchronised.
  assign core_rst = rst | ~rstn_sync[1];

  always_ff @(posedge clk) begin
    if (core_rst) begin
      cs_sync   <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      sclk_sync <= '0;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      dc_sync   <= {dc_sync[0], dc};
      sclk_sync <= {sclk_sync[0], sclk};
      sclk_q    <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_q;

  always_ff @(posedge clk) begin
    if (core_rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      done       <= 1'b0;
      dc_lat     <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      done       <= 1'b0;
      byte_valid <= done;
      if (done) begin
        byte_data <= shreg;
        byte_dc   <= dc_lat;
      end
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[6:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done   <= 1'b1;
          dc_lat <= dc_sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/st7735_rx.sv
// ST7735 panel-side responder: decodes CASET/RASET/RAMWR from the received
// byte stream and emits addressed RGB565 pixel writes.
module st7735_rx
  import st7735_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COORD_W = 8
) (
  input  logic               SYSTEM_CLK,
  input  logic               RESET,
  input  logic               CS,
  input  logic               MOSI,
  input  logic               DC,
  input  logic               LCD_CLK,
  input  logic               LCD_RST_N,
  output logic               BYTE_VALID,
  output logic [7:0]         BYTE_DATA,
  output logic               BYTE_DC,
  output logic               CMD_VALID,
  output logic [7:0]         CMD_CODE,
  output logic               PIX_VALID,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic [15:0]        PIX_DATA
);

  localparam logic [COORD_W-1:0] XE_DEF = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YE_DEF = COORD_W'(HEIGHT - 1);

  logic core_rst;

  spi_byte_rx u_byte_rx (
    .clk        (SYSTEM_CLK),
    .rst        (RESET),
    .cs_n       (CS),
    .mosi       (MOSI),
    .dc         (DC),
    .sclk       (LCD_CLK),
    .lcd_rst_n  (LCD_RST_N),
    .core_rst   (core_rst),
    .byte_valid (BYTE_VALID),
    .byte_data  (BYTE_DATA),
    .byte_dc    (BYTE_DC)
  );

  dec_state_t         state_q, state_d;
  logic [COORD_W-1:0] xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic [COORD_W-1:0] xs_d, xe_d, ys_d, ye_d, x_d, y_d;
  logic               phase_q, phase_d;
  logic [7:0]         hi_q, hi_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic               pix_valid_d;
  logic [COORD_W-1:0] pix_x_d, pix_y_d;
  logic [15:0]        pix_data_d;

  // Window values arrive as 16-bit big-endian pairs; only the low COORD_W
  // bits of {hi,lo} are kept, so each byte updates its share in place.
  function automatic logic [COORD_W-1:0] set_hi(input logic [COORD_W-1:0] cur,
                                                input logic [7:0] b);
    return COORD_W'({b, 8'(cur)});
  endfunction

  function automatic logic [COORD_W-1:0] set_lo(input logic [COORD_W-1:0] cur,
                                                input logic [7:0] b);
    return COORD_W'((16'(cur) & 16'hFF00) | {8'h00, b});
  endfunction

  assign CMD_VALID = BYTE_VALID & ~BYTE_DC;
  assign CMD_CODE  = CMD_VALID ? BYTE_DATA : cmd_code_q;

  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    cmd_code_d  = cmd_code_q;
    pix_valid_d = 1'b0;
    pix_x_d     = PIX_X;
    pix_y_d     = PIX_Y;
    pix_data_d  = PIX_DATA;
    if (BYTE_VALID) begin
      if (!BYTE_DC) begin
        cmd_code_d = BYTE_DATA;
        phase_d    = 1'b0;
        case (BYTE_DATA)
          CMD_CASET: state_d = ST_CASET0;
          CMD_RASET: state_d = ST_RASET0;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default:   state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET0: begin xs_d = set_hi(xs_q, BYTE_DATA); state_d = ST_CASET1; end
          ST_CASET1: begin xs_d = set_lo(xs_q, BYTE_DATA); state_d = ST_CASET2; end
          ST_CASET2: begin xe_d = set_hi(xe_q, BYTE_DATA); state_d = ST_CASET3; end
          ST_CASET3: begin xe_d = set_lo(xe_q, BYTE_DATA); state_d = ST_SKIP;   end
          ST_RASET0: begin ys_d = set_hi(ys_q, BYTE_DATA); state_d = ST_RASET1; end
          ST_RASET1: begin ys_d = set_lo(ys_q, BYTE_DATA); state_d = ST_RASET2; end
          ST_RASET2: begin ye_d = set_hi(ye_q, BYTE_DATA); state_d = ST_RASET3; end
          ST_RASET3: begin ye_d = set_lo(ye_q, BYTE_DATA); state_d = ST_SKIP;   end
          ST_RAMWR: begin
            if (!phase_q) begin
              hi_d    = BYTE_DATA;
              phase_d = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              pix_data_d  = {hi_q, BYTE_DATA};
              if (x_q == xe_q) begin
                x_d = xs_q;
                y_d = (y_q == ye_q) ? ys_q : y_q + COORD_W'(1);
              end else begin
                x_d = x_q + COORD_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (core_rst) begin
      state_q    <= ST_IDLE;
      xs_q       <= '0;
      xe_q       <= XE_DEF;
      ys_q       <= '0;
      ye_q       <= YE_DEF;
      x_q        <= '0;
      y_q        <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      cmd_code_q <= '0;
      PIX_VALID  <= 1'b0;
      PIX_X      <= '0;
      PIX_Y      <= '0;
      PIX_DATA   <= '0;
    end else begin
      state_q    <= state_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      x_q        <= x_d;
      y_q        <= y_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      cmd_code_q <= cmd_code_d;
      PIX_VALID  <= pix_valid_d;
      PIX_X      <= pix_x_d;
      PIX_Y      <= pix_y_d;
      PIX_DATA   <= pix_data_d;
    end
  end

endmodule

// File: tb/tb_st7735_rx.sv
// Directed bench for st7735_rx: drives SPI at SYSTEM_CLK/4 and checks bytes,
// commands and addressed pixels against hand-computed values.
module tb_st7735_rx;

  logic        SYSTEM_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic        DC = 1'b0;
  logic        LCD_CLK = 1'b0;
  logic        LCD_RST_N = 1'b1;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_DC;
  logic        CMD_VALID;
  logic [7:0]  CMD_CODE;
  logic        PIX_VALID;
  logic [7:0]  PIX_X;
  logic [7:0]  PIX_Y;
  logic [15:0] PIX_DATA;

  st7735_rx #(.WIDTH(128), .HEIGHT(160), .COORD_W(8)) dut (
    .SYSTEM_CLK (SYSTEM_CLK),
    .RESET      (RESET),
    .CS         (CS),
    .MOSI       (MOSI),
    .DC         (DC),
    .LCD_CLK    (LCD_CLK),
    .LCD_RST_N  (LCD_RST_N),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_DC    (BYTE_DC),
    .CMD_VALID  (CMD_VALID),
    .CMD_CODE   (CMD_CODE),
    .PIX_VALID  (PIX_VALID),
    .PIX_X      (PIX_X),
    .PIX_Y      (PIX_Y),
    .PIX_DATA   (PIX_DATA)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  int          total = 0;
  int          bad = 0;
  int          byte_cnt = 0;
  int          cmd_cnt = 0;
  logic [7:0]  last_byte = '0;
  logic        last_dc = 1'b0;
  logic [7:0]  last_cmd = '0;
  logic [31:0] pq[$];

  always @(negedge SYSTEM_CLK) begin
    if (BYTE_VALID) begin
      byte_cnt  <= byte_cnt + 1;
      last_byte <= BYTE_DATA;
      last_dc   <= BYTE_DC;
    end
    if (CMD_VALID) begin
      cmd_cnt  <= cmd_cnt + 1;
      last_cmd <= CMD_CODE;
    end
    if (PIX_VALID) pq.push_back({PIX_X, PIX_Y, PIX_DATA});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic dc, input logic [7:0] b, input int unsigned n);
    CS = 1'b0;
    DC = dc;
    for (int unsigned i = 0; i < n; i++) begin
      MOSI    = b[7 - i];
      LCD_CLK = 1'b0;
      repeat (2) @(negedge SYSTEM_CLK);
      LCD_CLK = 1'b1;
      repeat (2) @(negedge SYSTEM_CLK);
    end
    LCD_CLK = 1'b0;
    repeat (2) @(negedge SYSTEM_CLK);
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] b);
    spi_bits(dc, b, 8);
    repeat (4) @(negedge SYSTEM_CLK);
  endtask

  function automatic logic [63:0] outs();
    return 64'({BYTE_VALID, BYTE_DATA, BYTE_DC, CMD_VALID, CMD_CODE,
                PIX_VALID, PIX_X, PIX_Y, PIX_DATA});
  endfunction

  int b0, c0, p0;

  initial begin
    repeat (5) @(negedge SYSTEM_CLK);
    RESET = 1'b0;
    repeat (5) @(negedge SYSTEM_CLK);
    chk("reset_outs", outs(), 64'd0);

    // CASET 2..5
    b0 = byte_cnt; c0 = cmd_cnt; p0 = pq.size();
    spi_byte(1'b0, 8'h2A);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h02);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h05);
    chk("caset_cmds", 64'(cmd_cnt - c0), 64'd1);
    chk("caset_code", 64'(last_cmd), 64'h2A);
    chk("caset_bytes", 64'(byte_cnt - b0), 64'd5);
    chk("caset_nopix", 64'(pq.size() - p0), 64'd0);

    // RASET 10..11, RAMWR, 5 pixels
    p0 = pq.size();
    spi_byte(1'b0, 8'h2B);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h0A);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h0B);
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'hF8); spi_byte(1'b1, 8'h00);
    spi_byte(1'b1, 8'h07); spi_byte(1'b1, 8'hE0);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h1F);
    spi_byte(1'b1, 8'hFF); spi_byte(1'b1, 8'hFF);
    spi_byte(1'b1, 8'h12); spi_byte(1'b1, 8'h34);
    chk("ramwr_npix", 64'(pq.size() - p0), 64'd5);
    chk("ramwr_px0", 64'(pq[p0 + 0]), {32'd0, 8'd2, 8'd10, 16'hF800});
    chk("ramwr_px1", 64'(pq[p0 + 1]), {32'd0, 8'd3, 8'd10, 16'h07E0});
    chk("ramwr_px2", 64'(pq[p0 + 2]), {32'd0, 8'd4, 8'd10, 16'h001F});
    chk("ramwr_px3", 64'(pq[p0 + 3]), {32'd0, 8'd5, 8'd10, 16'hFFFF});
    chk("ramwr_px4", 64'(pq[p0 + 4]), {32'd0, 8'd2, 8'd11, 16'h1234});
    chk("ramwr_code", 64'(CMD_CODE), 64'h2C);

    // 1x2 window: row wrap back to YS
    p0 = pq.size();
    spi_byte(1'b0, 8'h2A);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h00);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h00);
    spi_byte(1'b0, 8'h2B);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h00);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h01);
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h11); spi_byte(1'b1, 8'h11);
    spi_byte(1'b1, 8'h22); spi_byte(1'b1, 8'h22);
    spi_byte(1'b1, 8'h33); spi_byte(1'b1, 8'h33);
    chk("wrap_npix", 64'(pq.size() - p0), 64'd3);
    chk("wrap_px0", 64'(pq[p0 + 0]), {32'd0, 8'd0, 8'd0, 16'h1111});
    chk("wrap_px1", 64'(pq[p0 + 1]), {32'd0, 8'd0, 8'd1, 16'h2222});
    chk("wrap_px2", 64'(pq[p0 + 2]), {32'd0, 8'd0, 8'd0, 16'h3333});

    // partial byte discarded when CS rises
    b0 = byte_cnt;
    spi_bits(1'b1, 8'hFF, 5);
    CS = 1'b1;
    repeat (4) @(negedge SYSTEM_CLK);
    spi_byte(1'b1, 8'hA5);
    chk("partial_bytes", 64'(byte_cnt - b0), 64'd1);
    chk("partial_data", 64'(last_byte), 64'hA5);
    chk("partial_dc", 64'(last_dc), 64'd1);

    // command mid-pixel drops the stored high byte
    p0 = pq.size();
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h55);
    spi_byte(1'b0, 8'h00);
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'hAB); spi_byte(1'b1, 8'hCD);
    chk("midpix_npix", 64'(pq.size() - p0), 64'd1);
    chk("midpix_px", 64'(pq[p0]), {32'd0, 8'd0, 8'd0, 16'hABCD});

    // LCD_RST_N mid-RAMWR restores the default window
    p0 = pq.size();
    spi_byte(1'b0, 8'h2A);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h03);
    spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h05);
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h01); spi_byte(1'b1, 8'h02);
    spi_byte(1'b1, 8'h77);
    chk("prerst_px", 64'(pq[p0]), {32'd0, 8'd3, 8'd0, 16'h0102});
    LCD_RST_N = 1'b0;
    repeat (6) @(negedge SYSTEM_CLK);
    chk("lcdrst_outs", outs(), 64'd0);
    LCD_RST_N = 1'b1;
    repeat (5) @(negedge SYSTEM_CLK);
    p0 = pq.size();
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h9A); spi_byte(1'b1, 8'hBC);
    spi_byte(1'b1, 8'hDE); spi_byte(1'b1, 8'hF0);
    chk("postrst_npix", 64'(pq.size() - p0), 64'd2);
    chk("postrst_px0", 64'(pq[p0 + 0]), {32'd0, 8'd0, 8'd0, 16'h9ABC});
    chk("postrst_px1", 64'(pq[p0 + 1]), {32'd0, 8'd1, 8'd0, 16'hDEF0});

    // RESET mid-byte clears every output on the next cycle
    spi_bits(1'b1, 8'hC3, 4);
    RESET = 1'b1;
    @(negedge SYSTEM_CLK);
    chk("reset_midbyte", outs(), 64'd0);
    RESET = 1'b0;
    CS = 1'b1;
    repeat (5) @(negedge SYSTEM_CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st7735_rx.md
Name: st7735_rx

Overview:
- Panel-side SPI responder: behavioural/synthesizable model of the ST7735 input interface, the receiving end of the ST7735 driver's CS/MOSI/DC/LCD_CLK/RESET lines.
- Samples the 4-wire write-only SPI in the SYSTEM_CLK domain and assembles bytes.
- Decodes CASET/RASET/RAMWR and emits addressed RGB565 pixel writes.
- Used in benches and on-FPGA loopback to check the driver without a physical panel.

Parameters:
- WIDTH, 128, panel columns; default column window end = WIDTH-1.
- HEIGHT, 160, panel rows; default row window end = HEIGHT-1.
- COORD_W, 8, width of pixel coordinate outputs; low COORD_W bits of 16-bit window values are used.

Ports:
- SYSTEM_CLK  in  1  system clock (12 MHz nominal); LCD_CLK must run at ≤ SYSTEM_CLK/4.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  panel chip select, active low.
- MOSI  in  1  serial data, MSB first, sampled on LCD_CLK rising edge.
- DC  in  1  0 = command byte, 1 = data byte.
- LCD_CLK  in  1  SPI clock, idle low.
- LCD_RST_N  in  1  panel hardware reset pin, active low.
- BYTE_VALID  out  1  one-cycle pulse per received byte.
- BYTE_DATA  out  8  received byte.
- BYTE_DC  out  1  DC value latched with the byte.
- CMD_VALID  out  1  one-cycle pulse per command byte.
- CMD_CODE  out  8  last command byte.
- PIX_VALID  out  1  one-cycle pulse per completed pixel.
- PIX_X  out  COORD_W  pixel column.
- PIX_Y  out  COORD_W  pixel row.
- PIX_DATA  out  16  RGB565 pixel, first byte is the high byte.

Behaviour:
- Input synchronization: CS, MOSI, DC, LCD_CLK and LCD_RST_N each pass through 2-FF synchronizers. LCD_CLK rising edge is detected on the registered (3rd stage) value.
- Reset values (RESET=1 or synced LCD_RST_N=0): all outputs 0; bit count 0; decoder state IDLE; XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1; X=0, Y=0.
- LCD_RST_N low acts like RESET and holds the block in reset.
- Bit capture: on each detected rising edge with synced CS=0, shift in MOSI and increment the bit count.
- On the 8th bit:
  - latch DC;
  - BYTE_VALID pulses exactly 3 SYSTEM_CLK cycles after the cycle in which LCD_CLK is first sampled high at the pin;
  - bit count returns to 0.
- Synced CS high: bit count cleared immediately and a partial byte is discarded with no pulse. Decoder state is retained across CS toggles, matching ST7735 behaviour.
- Decoder FSM, advanced only on BYTE_VALID:
  - Any byte with DC=0: CMD_VALID pulses in the same cycle as BYTE_VALID and CMD_CODE updates. Next state: 0x2A → CASET0, 0x2B → RASET0, 0x2C → RAMWR (loads X=XS, Y=YS, clears pixel phase), anything else → SKIP.
  - CASET0..3 (DC=1): XS_hi, XS_lo, XE_hi, XE_lo loaded in order; after byte 4 → SKIP. Extra bytes are ignored.
  - RASET0..3: same sequence for YS/YE.
  - RAMWR (DC=1), even phase: store the high byte.
  - RAMWR (DC=1), odd phase: PIX_VALID pulses the cycle after this BYTE_VALID, with PIX_X=X, PIX_Y=Y, PIX_DATA={hi, lo}. Then advance the address:
    - if X==XE: X=XS, and Y becomes YS if Y==YE, else Y+1;
    - otherwise X=X+1, modulo 2^COORD_W (so XS>XE wraps through 0, deterministically).
  - A command byte arriving mid-pixel drops the stored high byte.
  - SKIP / IDLE: data bytes only produce BYTE_VALID.
- A command byte arriving mid-CASET/RASET leaves the window registers partially updated; bytes already received are kept.
- A new CASET/RASET during RAMWR affects addressing only after the next RAMWR.

Decomposition:
- Shared package st7735_pkg holds:
  - command codes CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C, CMD_SWRESET=8'h01;
  - decoder state encoding;
  - default WIDTH/HEIGHT.
- The driver side imports the same constants.
- One sub-module, spi_byte_rx: synchronizers, edge detect, shift register and bit count, producing BYTE_VALID/BYTE_DATA/BYTE_DC. The top level holds the decoder FSM and address counters.

Test Plan:
- Send command 0x2A, then data 00 02 00 05, with LCD_CLK = SYSTEM_CLK/4 → CMD_VALID with CMD_CODE=8'h2A; XS=2, XE=5; 5 BYTE_VALID pulses; no PIX_VALID.
- RASET 00 0A 00 0B, RAMWR, then 10 data bytes F8 00 07 E0 00 1F FF FF 12 34 → pixels in order:
  - (2,10)=F800
  - (3,10)=07E0
  - (4,10)=001F
  - (5,10)=FFFF
  - (2,11)=1234
- Window XS=XE=0, YS=0, YE=1, RAMWR with 3 pixels → (0,0), (0,1), (0,0); row wrap verified.
- CS raised after 5 bits of a byte, then a full byte 0xA5 sent → single BYTE_VALID with data A5; the partial byte is discarded.
- RAMWR, one data byte, then command 0x00, then RAMWR and 2 bytes AB CD → exactly one PIX_VALID, data ABCD at (XS,YS).
- LCD_RST_N pulsed low mid-RAMWR, then RAMWR with 2 bytes → pixel at (0,0) with the default window; RESET asserted mid-byte → all outputs 0 the next cycle.
